q2_uart_out: RTL and testbench

//   Memory-mapped serial output port on the q2 CPU memory bus, sitting alongside the RAM.
//   CPU stores to DATA_ADDR push a 12-bit word into a small FIFO.
//   The FIFO drains through an 8N1 UART transmitter; each word goes out as two bytes.
//   CPU loads from STAT_ADDR return FIFO/transmitter status for polling.

---
 rtl/q2_uart_out.sv | 181 ++++++++++++++++++
 tb/tb_q2_uart_out.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_uart_out.sv
// q2_uart_out: memory-mapped serial output port on the q2 CPU bus.
//   CPU stores to DATA_ADDR queue 12-bit words in a small FIFO. Each word is
//   sent through an 8N1 UART as two frames: {4'b0, w[11:8]}, then w[7:0].
//   CPU loads from STAT_ADDR return
//   {4'b0, count[3:0], ovf, busy, empty, full}.
// Ports:
//   clk   in     system clock, all state on rising edge
//   rst   in     synchronous reset, active-high
//   abus  in  12 CPU address bus
//   dbus  io  12 CPU data bus; driven only during a status load, else 'z
//   wrm   in     CPU memory write strobe
//   rdm   in     CPU memory read strobe
//   txd   out    UART serial output, idle high
//   busy  out    transmitter not idle (registered)
module q2_uart_out #(
  parameter logic [11:0] DATA_ADDR    = 12'hFFF,
  parameter logic [11:0] STAT_ADDR    = 12'hFFE,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  wire  [11:0] dbus,
  input  logic        wrm,
  input  logic        rdm,
  output logic        txd,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DEPTH_C  = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          wrm_q, rdm_q;
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q;

  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_q;
  logic          byte_sel_q;
  logic [11:0]   w_q;
  logic          txd_q, busy_q;

  logic          wr_ev, rd_ev, full, empty, push, pop;
  logic [7:0]    tx_byte;
  logic [11:0]   status;

  // Bus decode: one event per strobe rising edge
  always_comb begin
    wr_ev   = wrm && !wrm_q && (abus == DATA_ADDR);
    rd_ev   = rdm && !rdm_q && (abus == STAT_ADDR);
    full    = (cnt_q == DEPTH_C);
    empty   = (cnt_q == 4'd0);
    // A push into a full FIFO is dropped even when a pop frees a slot this edge
    push    = wr_ev && !full;
    pop     = (state_q == IDLE) && !empty;
    tx_byte = byte_sel_q ? w_q[7:0] : {4'b0000, w_q[11:8]};
    status  = {4'b0000, cnt_q, ovf_q, busy_q, empty, full};
    cnt_d   = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 4'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign dbus = (rdm && (abus == STAT_ADDR)) ? status : 12'bz;
  assign txd  = txd_q;
  assign busy = busy_q;

  // FIFO control and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wrm_q  <= 1'b0;
      rdm_q  <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= 4'd0;
      ovf_q  <= 1'b0;
    end else begin
      wrm_q <= wrm;
      rdm_q <= rdm;
      cnt_q <= cnt_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      // A same-edge overflow takes priority over the read-clear
      if (wr_ev && full) begin
        ovf_q <= 1'b1;
      end else if (rd_ev) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // FIFO storage and shift-source word
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= dbus;
    end
    if (pop) begin
      w_q <= mem_q[rptr_q];
    end
  end

  // Transmitter FSM; txd/busy are registered from the current state,
  // so the line follows the state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_q      <= 3'd0;
      byte_sel_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE);
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= tx_byte[bit_q];
        default: txd_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (!empty) begin
            byte_sel_q <= 1'b0;
            clk_cnt_q  <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (clk_cnt_q == CLK_LAST) begin
            clk_cnt_q <= '0;
            bit_q     <= 3'd0;
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_q == CLK_LAST) begin
            clk_cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt_q == CLK_LAST) begin
            clk_cnt_q <= '0;
            if (!byte_sel_q) begin
              byte_sel_q <= 1'b1;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q2_uart_out.sv
// tb_q2_uart_out: directed/randomized bench for q2_uart_out with a
// behavioural UART receiver and an expected-byte scoreboard.
module tb_q2_uart_out;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam logic [11:0] DATA_A = 12'hFFF;
  localparam logic [11:0] STAT_A = 12'hFFE;

  logic        clk = 1'b0;
  logic        rst, wrm, rdm;
  logic [11:0] abus, drv;
  logic        drv_en;
  wire  [11:0] dbus;
  logic        txd, busy;

  assign dbus = drv_en ? drv : 12'bz;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  bit         rx_en   = 1'b0;
  logic [7:0] rx_b;
  bit         rx_ok;

  q2_uart_out #(
    .DATA_ADDR   (12'hFFF),
    .STAT_ADDR   (12'hFFE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .abus(abus),
    .dbus(dbus),
    .wrm (wrm),
    .rdm (rdm),
    .txd (txd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] stat(input int cnt, input bit ovf, input bit bsy);
    stat = {4'b0000, 4'(cnt), ovf, bsy, (cnt == 0), (cnt == DEPTH)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [11:0] a, input logic [11:0] d);
    abus = a; drv = d; drv_en = 1'b1; wrm = 1'b1;
    tick();
    wrm = 1'b0; drv_en = 1'b0; abus = 12'h000;
  endtask

  task automatic read_status(output logic [11:0] v);
    abus = STAT_A; rdm = 1'b1;
    #1;
    v = dbus;
    tick();
    rdm = 1'b0; abus = 12'h000;
    tick();
  endtask

  // Expected line level for one word, straight from the 8N1 framing rule
  task automatic check_word_wave(input logic [11:0] w, input string tag);
    bit         lvl[$];
    logic [7:0] bytes[2];
    bytes[0] = {4'b0000, w[11:8]};
    bytes[1] = w[7:0];
    for (int k = 0; k < 2; k++) begin
      lvl.push_back(1'b0);
      for (int i = 0; i < 8; i++) lvl.push_back(bytes[k][i]);
      lvl.push_back(1'b1);
      exp_q.push_back(bytes[k]);
    end
    tick();
    chk({tag, "_txd_pop"}, 12'(txd), 12'd1);
    chk({tag, "_busy_pop"}, 12'(busy), 12'd0);
    for (int c = 0; c < 20 * CPB; c++) begin
      tick();
      chk($sformatf("%s_txd_c%0d", tag, c), 12'(txd), 12'(lvl[c / CPB]));
      chk($sformatf("%s_busy_c%0d", tag, c), 12'(busy), 12'd1);
    end
    tick();
    chk({tag, "_busy_end"}, 12'(busy), 12'd0);
    chk({tag, "_txd_end"}, 12'(txd), 12'd1);
  endtask

  task automatic drain(input string tag);
    int lows = 0;
    bit ok   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (busy == 1'b0) lows++; else lows = 0;
      if (lows >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_drain"}, 12'(ok), 12'd1);
    repeat (4) tick();
  endtask

  task automatic compare_rx(input string tag);
    int n;
    chk({tag, "_rx_count"}, 12'(rx_q.size()), 12'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_rx_byte%0d", tag, i), 12'(rx_q[i]), 12'(exp_q[i]));
    chk({tag, "_rx_framing"}, 12'(rx_ferr), 12'd0);
    rx_q.delete();
    exp_q.delete();
    rx_ferr = 0;
  endtask

  // Behavioural 8N1 receiver sampling mid-bit on the falling clock edge
  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && txd === 1'b0) begin
        rx_ok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (txd !== 1'b0) rx_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (txd !== 1'b1) rx_ok = 1'b0;
        if (rx_ok) rx_q.push_back(rx_b); else rx_ferr++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] v, wv;
    logic [11:0] words[10];
    int          lowc, n, found;

    rst = 1'b1; wrm = 1'b0; rdm = 1'b0; abus = 12'h000; drv = 12'h000; drv_en = 1'b0;
    tick();
    tick();
    chk("rst_txd", 12'(txd), 12'd1);
    chk("rst_busy", 12'(busy), 12'd0);
    rst = 1'b0;
    tick();
    rx_en = 1'b1;

    // 1: idle status after reset
    read_status(v);
    chk("t1_status", v, 12'h002);
    chk("t1_txd", 12'(txd), 12'd1);
    chk("t1_busy", 12'(busy), 12'd0);

    // 2: exact waveform of 12'hABC, then random words
    store(DATA_A, 12'hABC);
    check_word_wave(12'hABC, "t2");
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 4)) tick();
      wv = 12'($urandom);
      store(DATA_A, wv);
      check_word_wave(wv, $sformatf("t2r%0d", r));
    end
    compare_rx("t2");

    // 3: ten back-to-back stores, overflow and read-clear
    for (int i = 0; i < 10; i++) begin
      words[i] = 12'($urandom);
      store(DATA_A, words[i]);
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({4'b0000, words[i][11:8]});
      exp_q.push_back(words[i][7:0]);
    end
    read_status(v);
    chk("t3_status1", v, 12'h08D);
    read_status(v);
    chk("t3_status2", v, 12'h085);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (busy == 1'b0) begin
        found = 1;
        break;
      end
    end
    chk("t3_gap_seen", 12'(found), 12'd1);
    chk("t3_gap_txd", 12'(txd), 12'd1);
    tick();
    chk("t3_next_busy", 12'(busy), 12'd1);
    chk("t3_next_start", 12'(txd), 12'd0);
    drain("t3");
    compare_rx("t3");
    read_status(v);
    chk("t3_status_end", v, stat(0, 1'b0, 1'b0));

    // 4: held write strobe queues exactly one word
    store(DATA_A, 12'h3C5);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'hC5);
    tick();
    tick();
    abus = DATA_A; drv = 12'h91E; drv_en = 1'b1; wrm = 1'b1;
    tick();
    drv = 12'h6E1;
    repeat (4) tick();
    wrm = 1'b0; drv_en = 1'b0; abus = 12'h000;
    tick();
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h1E);
    read_status(v);
    chk("t4_status", v, stat(1, 1'b0, 1'b1));
    drain("t4");
    compare_rx("t4");

    // 5: store to status address and load from data address are ignored
    store(STAT_A, 12'h123);
    tick();
    tick();
    abus = DATA_A; rdm = 1'b1; drv = 12'h5A5; drv_en = 1'b1;
    #1;
    chk("t5_load_data_addr", dbus, 12'h5A5);
    tick();
    rdm = 1'b0; abus = STAT_A; drv = 12'hA5A;
    #1;
    chk("t5_stat_no_rdm", dbus, 12'hA5A);
    drv_en = 1'b0; abus = 12'h000;
    lowc = 0;
    repeat (20) begin
      tick();
      if (txd == 1'b0 || busy == 1'b1) lowc++;
    end
    chk("t5_no_activity", 12'(lowc), 12'd0);
    read_status(v);
    chk("t5_status", v, 12'h002);

    // 6: reset mid-frame with three words queued
    for (int i = 0; i < 4; i++) begin
      store(DATA_A, 12'($urandom));
      tick();
    end
    read_status(v);
    chk("t6_status_pre", v, stat(3, 1'b0, 1'b1));
    rst = 1'b1;
    tick();
    chk("t6_rst_txd", 12'(txd), 12'd1);
    chk("t6_rst_busy", 12'(busy), 12'd0);
    rst = 1'b0;
    read_status(v);
    chk("t6_status_post", v, 12'h002);
    lowc = 0;
    repeat (200) begin
      tick();
      if (txd == 1'b0 || busy == 1'b1) lowc++;
    end
    chk("t6_quiet", 12'(lowc), 12'd0);
    rx_q.delete();
    exp_q.delete();
    rx_ferr = 0;

    // 7: random burst with random gaps
    n = $urandom_range(3, 6);
    for (int i = 0; i < n; i++) begin
      wv = 12'($urandom);
      store(DATA_A, wv);
      exp_q.push_back({4'b0000, wv[11:8]});
      exp_q.push_back(wv[7:0]);
      repeat ($urandom_range(1, 4)) tick();
    end
    drain("t7");
    compare_rx("t7");
    read_status(v);
    chk("t7_status_end", v, 12'h002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
